// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared FSM encoding and default width for the bit-serial subtractor
package serial_sub_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;
    localparam int WIDTH_DEF = 4;
endpackage

// File: rtl/serial_sub_fs.sv
// serial_sub_fs: single-bit combinational full subtractor cell
module serial_sub_fs (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);
    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~(x ^ y) & bi);
endmodule

// File: rtl/serial_sub.sv
// serial_sub: bit-serial subtractor, one result bit per clock, LSB first
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);
    localparam int CW = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d, b_sr_q, b_sr_d, dsr_q, dsr_d, diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             brw_q, brw_d, bout_q, bout_d;
    logic             fs_d, fs_bo, shift, load, last;

    assign shift = state_q == ST_SHIFT;
    assign load  = start && !shift;
    assign last  = shift && cnt_q == CW'(WIDTH - 1);

    serial_sub_fs u_fs (
        .x (a_sr_q[0]),
        .y (b_sr_q[0]),
        .bi(brw_q),
        .d (fs_d),
        .bo(fs_bo)
    );

    // state register and datapath flops
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            dsr_q   <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            brw_q   <= 1'b0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            dsr_q   <= dsr_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            brw_q   <= brw_d;
            bout_q  <= bout_d;
        end
    end

    // next state: accept from IDLE or DONE, leave SHIFT after the last bit
    always_comb begin
        state_d = load ? ST_SHIFT : shift ? (last ? ST_DONE : ST_SHIFT) : ST_IDLE;
    end

    // FSM outputs
    always_comb begin
        busy = shift;
        done = state_q == ST_DONE;
    end

    // datapath: load operands on accept, shift one bit per SHIFT cycle, publish on the last bit
    always_comb begin
        a_sr_d = load ? a : shift ? a_sr_q >> 1 : a_sr_q;
        b_sr_d = load ? b : shift ? b_sr_q >> 1 : b_sr_q;
        dsr_d  = load ? '0 : shift ? {fs_d, dsr_q[WIDTH-1:1]} : dsr_q;
        brw_d  = load ? bin : shift ? fs_bo : brw_q;
        cnt_d  = (load || last) ? '0 : shift ? cnt_q + CW'(1) : cnt_q;
        diff_d = last ? {fs_d, dsr_q[WIDTH-1:1]} : diff_q;
        bout_d = last ? fs_bo : bout_q;
    end

    assign diff = diff_q;
    assign bout = bout_q;
endmodule
